// File: rtl/arrowzip_btn_pkg.sv
// Shared constants and helpers for the push-button conditioner.
// Default timings assume an 80 MHz system clock.
package arrowzip_btn_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 80000;
    localparam int DEFAULT_LONG_CYCLES     = 80000000;

    // Bits needed to hold any value in 0..v-1; never less than 1.
    function automatic int clog2(input longint unsigned v);
        int r;
        r = 0;
        for (int i = 0; i < 63; i++) begin
            if ((64'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/btn_debounce_chan.sv
// One button channel: two-flop synchroniser, stability counter, level and event flags.
// Long-press detection is built only when BTN_LONGPRESS_EN is defined.
module btn_debounce_chan
    import arrowzip_btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES
)(
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_pin,
    output logic o_btn,
    output logic o_btn_nxt,
    output logic o_press,
    output logic o_release,
    output logic o_long
);

    localparam int             CW       = clog2(longint'(DEBOUNCE_CYCLES) + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("btn_debounce_chan: DEBOUNCE_CYCLES must be >= 1");
    end
    if (LONG_CYCLES < 1) begin : g_bad_long
        $error("btn_debounce_chan: LONG_CYCLES must be >= 1");
    end

    logic          sync_p0;
    logic          sync_p1;
    logic [CW-1:0] cnt;
    logic          settle;

    // The level flips on the edge that completes DEBOUNCE_CYCLES consecutive mismatches.
    assign settle    = (sync_p1 != o_btn) && (cnt == CNT_LAST);
    assign o_btn_nxt = settle ? sync_p1 : o_btn;

    // Stage p0/p1: synchroniser; level stage follows.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync_p0   <= 1'b0;
            sync_p1   <= 1'b0;
            cnt       <= '0;
            o_btn     <= 1'b0;
            o_press   <= 1'b0;
            o_release <= 1'b0;
        end else begin
            sync_p0   <= i_pin;
            sync_p1   <= sync_p0;
            if (sync_p1 == o_btn || settle) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            o_btn     <= o_btn_nxt;
            o_press   <= settle &  sync_p1;
            o_release <= settle & ~sync_p1;
        end
    end

`ifdef BTN_LONGPRESS_EN
    localparam int            HW        = clog2(longint'(LONG_CYCLES) + 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

    logic [HW-1:0] hold;

    // Saturating at HOLD_MAX makes the pulse fire once per press.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            hold   <= '0;
            o_long <= 1'b0;
        end else begin
            o_long <= 1'b0;
            if (!o_btn) begin
                hold <= '0;
            end else if (hold != HOLD_MAX) begin
                hold   <= hold + HW'(1);
                o_long <= (hold == HOLD_LAST);
            end
        end
    end
`else
    assign o_long = 1'b0;
`endif

endmodule

// File: rtl/btn_debouncer.sv
// Multi-channel push-button conditioner: pin inversion, per-channel debounce, any-pressed flag.
// Optional long-press pulses are enabled with BTN_LONGPRESS_EN.
module btn_debouncer
    import arrowzip_btn_pkg::*;
#(
    parameter int              NBTN            = 2,
    parameter int              DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic [NBTN-1:0] INVERT          = '1,
    parameter int              LONG_CYCLES     = DEFAULT_LONG_CYCLES
)(
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic [NBTN-1:0] i_btn,
    output logic [NBTN-1:0] o_btn,
    output logic [NBTN-1:0] o_press,
    output logic [NBTN-1:0] o_release,
    output logic            o_any,
    output logic [NBTN-1:0] o_long
);

    if (NBTN < 1 || NBTN > 8) begin : g_bad_nbtn
        $error("btn_debouncer: NBTN must be in 1..8");
    end

    logic [NBTN-1:0] pin;
    logic [NBTN-1:0] btn_nxt;

    // Normalise so that 1 always means pressed before synchronising.
    assign pin = i_btn ^ INVERT;

    for (genvar k = 0; k < NBTN; k++) begin : g_chan
        btn_debounce_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES)
        ) u_chan (
            .i_clk     (i_clk),
            .i_reset_n (i_reset_n),
            .i_pin     (pin[k]),
            .o_btn     (o_btn[k]),
            .o_btn_nxt (btn_nxt[k]),
            .o_press   (o_press[k]),
            .o_release (o_release[k]),
            .o_long    (o_long[k])
        );
    end

    // OR of next levels so o_any changes in the same cycle as o_btn.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_any <= 1'b0;
        end else begin
            o_any <= |btn_nxt;
        end
    end

endmodule
